cla_nibble_sequencer: RTL
=========================

# cla_nibble_sequencer

Two-requester controller that shares one 4-bit carry-lookahead adder slice and uses it to perform WIDTH-bit additions one nibble per cycle, least significant nibble first. It arbitrates between requesters round-robin and sequences the slice, passing the carry from nibble to nibble. It presents the full-width sum, carry-out and signed overflow on a valid/ready response port. It sits between the operand sources and the downstream consumer, so wide adds never need a wide adder.

## Interface
- WIDTH, 16: operand and sum width. Must be a multiple of 4 and at least 4. NIBBLES = WIDTH/4.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req0_valid / req1_valid  in  1  requester n has an operation pending.
- req0_ready / req1_ready  out  1  requester n's operation is accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands, unsigned or two's complement.
- req0_cin / req1_cin  in  1  carry-in.
- rsp_valid  out  1  response is valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_sum  out  WIDTH  sum, (a + b + cin) mod 2^WIDTH.
- rsp_cout  out  1  carry out of the most significant nibble.
- rsp_ovf  out  1  signed overflow, computed as carry into MSB XOR carry out of MSB.
- rsp_id  out  1  index of the requester that was served.

## Operation
- FSM states are IDLE, RUN and DONE. Reset value is IDLE.
- **IDLE**
  - If any reqN_valid is high, grant exactly one requester. Its reqN_ready is high combinationally in this cycle.
  - At the clock edge, capture a, b and cin, set the nibble index to 0, latch rsp_id, and move to RUN.
  - reqN_ready is never high outside IDLE. Both ready signals are never high together.
- **Arbitration**
  - If only one requester is valid, it is granted.
  - If both are valid, grant the one not granted last time.
  - The last-granted pointer updates only on acceptance. Its reset value makes req0 win the first contention.
- **RUN**
  - Each cycle, the slice adds a[4i+3:4i], b[4i+3:4i] and the carry register.
  - The result goes to sum nibble i. The slice's c4 goes to the carry register. The index increments.
  - On the final nibble (i = NIBBLES-1), also latch rsp_cout = c4 and rsp_ovf = c3 XOR c4 of that nibble, then go to DONE.
  - The index never exceeds NIBBLES-1.
- **DONE**
  - rsp_valid is high. On rsp_valid && rsp_ready, return to IDLE.
  - No requester is accepted in DONE, even if rsp_ready is high.
- **Reset values**
  - rsp_valid, reqN_ready, rsp_sum, rsp_cout, rsp_ovf and rsp_id are all 0.
  - The carry register and nibble index are 0. The pointer is set so req0 is favoured.
- **Reset mid-operation**
  - Asserting rst_n clears the state immediately, asynchronously, in any state. The in-flight operation is discarded and no response is issued.
  - After rst_n deasserts, the block starts in IDLE.
- **Operand stability**: requesters may change operands after acceptance. The block uses only its captured copies.

## Timing
- Accept edge is T0, when reqN_valid && reqN_ready.
- RUN occupies the cycles after edges T0 .. T0+NIBBLES-1. rsp_valid rises after edge T0+NIBBLES.
  - For WIDTH=16 this is 4 cycles after the accept edge.
- While rsp_valid && !rsp_ready, rsp_sum, rsp_cout, rsp_ovf and rsp_id stay constant.
- With rsp_ready high in the first DONE cycle, the block is in IDLE after the next edge. The minimum operation-to-operation period is NIBBLES+2 cycles.
- rsp_sum bits for nibbles not yet computed may hold stale data during RUN. They are defined only while rsp_valid is high.

## Test plan
- **Carry across nibbles.** WIDTH=16, req0 only, a=0x00FF, b=0x0001, cin=0.
  - Response: rsp_sum=0x0100, cout=0, ovf=0, id=0.
  - rsp_valid first high 4 cycles after the accept edge.
- **Carry-out and overflow.** req1 only, a=0xFFFF, b=0x0001, cin=0 gives sum=0x0000, cout=1, ovf=0, id=1.
  - Then a=0x7FFF, b=0x0001, cin=0 gives sum=0x8000, cout=0, ovf=1.
- **Carry-in.** a=0xFFFF, b=0xFFFF, cin=1 gives sum=0xFFFF, cout=1, ovf=0.
- **Round-robin.** Both requesters held valid with distinct operands for 4 operations.
  - Grants follow the order 0,1,0,1.
  - Each rsp_id and rsp_sum matches its requester.
  - Ready is never high for both requesters in the same cycle.
- **Backpressure.** Hold rsp_ready=0 for 5 cycles after rsp_valid rises.
  - Response outputs stay stable and both reqN_ready stay 0.
  - Raising rsp_ready completes the handshake, and the next accept occurs one cycle later.
- **Reset mid-operation.** Assert rst_n low during RUN at nibble index 2.
  - All outputs go to 0 immediately, and no response is issued.
  - After release, req0 a=0x1234, b=0x1111, cin=0 gives sum=0x2345, id=0.

Source files
------------

// File: rtl/cla_nibble_sequencer.sv
// Shares one 4-bit carry-lookahead slice between two requesters and performs
// WIDTH-bit additions one nibble per cycle, LSB nibble first, round-robin arbitrated.
//
// state | meaning
// IDLE  | waiting for a request; grants one requester and captures its operands
// RUN   | one nibble per cycle through the slice, carry chained in carry_q
// DONE  | response held on rsp_* until the consumer takes it
module cla_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic             rsp_id
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx;
    logic             last_grant;
    logic             cout_q, ovf_q, id_q;
    logic             grant0, grant1;

    logic [3:0] nib_a, nib_b, nib_s, nib_g, nib_p;
    logic [4:0] nib_c;

    // Carry-lookahead slice: every carry is a flat sum of products of g/p/c0.
    always_comb begin
        nib_a    = a_q[4*idx +: 4];
        nib_b    = b_q[4*idx +: 4];
        nib_g    = nib_a & nib_b;
        nib_p    = nib_a ^ nib_b;
        nib_c[0] = carry_q;
        nib_c[1] = nib_g[0] | (nib_p[0] & nib_c[0]);
        nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & nib_c[0]);
        nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[2] & nib_p[1] & nib_p[0] & nib_c[0]);
        nib_c[4] = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
                 | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & nib_c[0]);
        nib_s    = nib_p ^ nib_c[3:0];
    end

    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            IDLE: begin
                // last_grant == 1 means req1 won last, so req0 wins a contention
                if (req1_valid && (!req0_valid || !last_grant)) grant1 = 1'b1;
                else if (req0_valid)                            grant0 = 1'b1;
                if (grant0 || grant1) state_nxt = RUN;
            end
            RUN:     if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            idx        <= '0;
            last_grant <= 1'b1;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            id_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant0 || grant1) begin
                    a_q        <= grant1 ? req1_a : req0_a;
                    b_q        <= grant1 ? req1_b : req0_b;
                    carry_q    <= grant1 ? req1_cin : req0_cin;
                    idx        <= '0;
                    id_q       <= grant1;
                    last_grant <= grant1;
                end
                RUN: begin
                    sum_q[4*idx +: 4] <= nib_s;
                    carry_q           <= nib_c[4];
                    if (idx == LAST_IDX) begin
                        cout_q <= nib_c[4];
                        ovf_q  <= nib_c[3] ^ nib_c[4];
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gating with rst_n keeps ready low while reset is held, even with valid high.
    assign req0_ready = grant0 & rst_n;
    assign req1_ready = grant1 & rst_n;
    assign rsp_valid  = (state == DONE);
    assign rsp_sum    = sum_q;
    assign rsp_cout   = cout_q;
    assign rsp_ovf    = ovf_q;
    assign rsp_id     = id_q;
endmodule
